traffic_request_conditioner: RTL and testbench

Input conditioning stage between the raw pedestrian push-button / vehicle loop sensor and the traffic controller FSM. It synchronizes both asynchronous inputs, debounces them, and converts each debounced rising edge into a sticky request flag. Each flag stays set until the controller acknowledges it. It also counts presses that arrive while a walk request is already pending. All logic runs on the system `clk`; the controller samples the flags on its own 1 Hz schedule and pulses the acks.

---
 rtl/traffic_request_conditioner.sv | 93 +++++++++
 tb/tb_traffic_request_conditioner.sv | 137 +++++++++++++
 2 files changed

// File: rtl/traffic_request_conditioner.sv
// Conditions the raw vehicle-sensor and pedestrian-button inputs into debounced
// levels and sticky request flags for the traffic controller.
module traffic_request_conditioner #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned CNT_W           = 8
) (
   input  logic       clk,
   input  logic       Reset_n,
   input  logic       Sensor,
   input  logic       Walk_Request,
   input  logic       Sensor_Ack,
   input  logic       Walk_Ack,
   output logic       Sensor_Level,
   output logic       Walk_Level,
   output logic       Sensor_Pending,
   output logic       Walk_Pending,
   output logic [3:0] Walk_Dropped
);

   localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Channel index 0 is the vehicle sensor, index 1 the pedestrian button.
   logic [1:0]             raw, ack, s;
   logic [1:0]             st_q, st_d;
   logic [1:0]             pend_q, pend_d;
   logic [1:0]             rise;
   logic [SYNC_STAGES-1:0] sync_q [2];
   logic [CNT_W-1:0]       cnt_q  [2];
   logic [CNT_W-1:0]       cnt_d  [2];
   logic [3:0]             drop_q, drop_d;

   assign raw = {Walk_Request, Sensor};
   assign ack = {Walk_Ack, Sensor_Ack};
   assign s   = {sync_q[1][SYNC_STAGES-1], sync_q[0][SYNC_STAGES-1]};

   always_comb begin
      st_d   = st_q;
      pend_d = pend_q;
      rise   = '0;
      for (int i = 0; i < 2; i++) begin
         cnt_d[i] = '0;
         if (s[i] != st_q[i]) begin
            if (cnt_q[i] == CntMax) begin
               st_d[i] = s[i];
               rise[i] = s[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
         // A rise beats a simultaneous ack so no request is ever lost.
         if (rise[i]) begin
            pend_d[i] = 1'b1;
         end else if (ack[i]) begin
            pend_d[i] = 1'b0;
         end
      end
   end

   always_comb begin
      drop_d = drop_q;
      if (rise[1] && pend_q[1] && !Walk_Ack && (drop_q != 4'hF)) begin
         drop_d = drop_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < 2; i++) begin
            sync_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
         st_q   <= '0;
         pend_q <= '0;
         drop_q <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
            cnt_q[i]  <= cnt_d[i];
         end
         st_q   <= st_d;
         pend_q <= pend_d;
         drop_q <= drop_d;
      end
   end

   assign Sensor_Level   = st_q[0];
   assign Walk_Level     = st_q[1];
   assign Sensor_Pending = pend_q[0];
   assign Walk_Pending   = pend_q[1];
   assign Walk_Dropped   = drop_q;

endmodule

// File: tb/tb_traffic_request_conditioner.sv
// Directed bench for traffic_request_conditioner: inputs change 1 ns after a
// rising edge, outputs are sampled 1 ns after the following edges.
module tb_traffic_request_conditioner;

   logic       clk = 1'b0;
   logic       Reset_n;
   logic       Sensor, Walk_Request, Sensor_Ack, Walk_Ack;
   logic       sl, wl, sp, wp;
   logic [3:0] wd;
   int         checks   = 0;
   int         failures = 0;

   traffic_request_conditioner dut (
      .clk            (clk),
      .Reset_n        (Reset_n),
      .Sensor         (Sensor),
      .Walk_Request   (Walk_Request),
      .Sensor_Ack     (Sensor_Ack),
      .Walk_Ack       (Walk_Ack),
      .Sensor_Level   (sl),
      .Walk_Level     (wl),
      .Sensor_Pending (sp),
      .Walk_Pending   (wp),
      .Walk_Dropped   (wd)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [7:0] outs();
      return {sl, wl, sp, wp, wd};
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      Reset_n = 1'b0; Sensor = 1'b0; Walk_Request = 1'b0;
      Sensor_Ack = 1'b0; Walk_Ack = 1'b0;

      // Reset and idle
      tick(3);
      chk("reset_outs", outs(), 8'h00);
      Reset_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         chk("idle_outs", outs(), 8'h00);
      end

      // Clean press: level and pending rise on the 6th edge
      Walk_Request = 1'b1;
      tick(5);
      chk("press_e4", outs(), 8'h00);
      tick(1);
      chk("press_e5", outs(), 8'h50);
      tick(4);
      Walk_Request = 1'b0;
      Walk_Ack = 1'b1;
      tick(1);
      Walk_Ack = 1'b0;
      chk("ack_clears_wp", {7'd0, wp}, 8'h00);
      chk("ack_keeps_wl", {7'd0, wl}, 8'h01);
      tick(6);
      chk("release_fall", outs(), 8'h00);

      // Glitch rejection on sensor
      Sensor = 1'b1; tick(3);
      Sensor = 1'b0; tick(1);
      chk("glitch_mid", outs(), 8'h00);
      Sensor = 1'b1; tick(3);
      Sensor = 1'b0;
      chk("glitch_hi2", outs(), 8'h00);
      tick(8);
      chk("glitch_end", outs(), 8'h00);

      // Minimum 4-cycle pulse is accepted
      Sensor = 1'b1; tick(4);
      Sensor = 1'b0; tick(1);
      chk("pulse4_e4", outs(), 8'h00);
      tick(1);
      chk("pulse4_e5", outs(), 8'hA0);
      tick(4);
      chk("pulse4_fall", outs(), 8'h20);
      Sensor_Ack = 1'b1; tick(1); Sensor_Ack = 1'b0;
      chk("sensor_ack", outs(), 8'h00);
      Sensor_Ack = 1'b1; tick(1); Sensor_Ack = 1'b0;
      chk("ack_when_idle", outs(), 8'h00);

      // Rise/ack collision: rise wins, no drop counted
      Walk_Request = 1'b1; tick(6);
      chk("set_wp", outs(), 8'h50);
      Walk_Request = 1'b0; tick(10);
      chk("wp_held", outs(), 8'h10);
      Walk_Request = 1'b1; tick(5);
      Walk_Ack = 1'b1; tick(1); Walk_Ack = 1'b0;
      chk("collision", outs(), 8'h50);
      Walk_Request = 1'b0; tick(10);
      chk("collision_after", outs(), 8'h10);

      // Dropped-press saturation
      for (int k = 1; k <= 17; k++) begin
         Walk_Request = 1'b1; tick(10);
         Walk_Request = 1'b0; tick(10);
         chk($sformatf("dropped_%0d", k), {4'd0, wd}, 8'(k > 15 ? 15 : k));
      end
      chk("wp_after_sat", {7'd0, wp}, 8'h01);

      // Reset mid-debounce with sensor held high
      Sensor = 1'b1; tick(4);
      Reset_n = 1'b0; #1;
      chk("async_reset", outs(), 8'h00);
      tick(1);
      Reset_n = 1'b1;
      tick(5);
      chk("post_reset_e4", outs(), 8'h00);
      tick(1);
      chk("post_reset_e5", outs(), 8'hA0);
      Sensor_Ack = 1'b1; tick(1); Sensor_Ack = 1'b0;
      tick(20);
      chk("single_rise", outs(), 8'h80);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
